// File: rtl/coreuart_pkg.sv
// Shared UART definitions: default generator sizing, the oversample
// counter width helper, and the tick bundle handed to the TX/RX shifters.
package coreuart_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_FRAC_W = 4;
    localparam int DEF_OVS    = 16;

    // Width of a counter that walks 0..ovs-1 (ovs is a power of two).
    function automatic int ovs_w(input int ovs);
        return $clog2(ovs);
    endfunction

    // One-cycle strobes issued together on a sample boundary.
    typedef struct packed {
        logic sample;    // every oversample period
        logic mid;       // RX data-sampling point inside the bit
        logic boundary;  // end of bit, TX shifts here
    } tick_bundle_t;

endpackage

// File: rtl/coreuart_baud_gen_frac_if.sv
// Control/tick bundle between the APB register file / shifters and the
// baud generator. The generator uses the slave side.
interface coreuart_baud_gen_frac_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) ();
    // BAUD_FRAC stays one bit wide when the fraction path is compiled out.
    localparam int FRAC_BITS = (FRAC_W > 0) ? FRAC_W : 1;

    logic                 ENABLE;
    logic [DIV_W-1:0]     BAUD_VAL;
    logic [FRAC_BITS-1:0] BAUD_FRAC;
    logic                 RESYNC;
    logic                 SAMPLE_TICK;
    logic                 MID_TICK;
    logic                 BIT_TICK;

    modport master (
        output ENABLE, BAUD_VAL, BAUD_FRAC, RESYNC,
        input  SAMPLE_TICK, MID_TICK, BIT_TICK
    );

    modport slave (
        input  ENABLE, BAUD_VAL, BAUD_FRAC, RESYNC,
        output SAMPLE_TICK, MID_TICK, BIT_TICK
    );
endinterface

// File: rtl/coreuart_frac_acc.sv
// Fractional phase accumulator. Each step adds the addend modulo 2^FRAC_W;
// carry is the combinational overflow of acc + addend, so the caller sees
// the carry belonging to the step it is about to take.
module coreuart_frac_acc #(
    parameter int FRAC_W = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              load,
    input  logic [FRAC_W-1:0] load_val,
    input  logic              step,
    input  logic [FRAC_W-1:0] addend,
    output logic              carry
);
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, addend};
    assign carry = sum[FRAC_W];

    // clear beats load beats step
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (load)
            acc <= load_val;
        else if (step)
            acc <= sum[FRAC_W-1:0];
    end
endmodule

// File: rtl/coreuart_baud_gen_frac.sv
// Fractional baud generator: a down-counting divider reloaded with
// BAUD_VAL (+1 cycle when the fraction accumulator carries), followed by
// an oversample counter that marks the mid-bit and bit-boundary ticks.
// Divisors are only sampled at reload/resync, so updates never produce a
// runt or stretched period.
module coreuart_baud_gen_frac
    import coreuart_pkg::*;
#(
    parameter int DIV_W  = DEF_DIV_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int OVS    = DEF_OVS
) (
    input  logic                      CLK,
    input  logic                      RESET,
    coreuart_baud_gen_frac_if.slave   bus
);
    localparam int OVS_W = ovs_w(OVS);

    // One extra bit so BAUD_VAL max plus carry still fits.
    logic [DIV_W:0]     div_cnt;
    logic [OVS_W-1:0]   ovs_cnt;
    logic               carry;
    logic               tick_d;
    logic               acc_clear;
    tick_bundle_t       ticks;

    assign tick_d    = bus.ENABLE & ~bus.RESYNC & (div_cnt == '0);
    assign acc_clear = ~bus.ENABLE | bus.RESYNC;

    generate
        if (FRAC_W > 0) begin : g_frac
            coreuart_frac_acc #(.FRAC_W(FRAC_W)) u_frac_acc (
                .CLK      (CLK),
                .RESET    (RESET),
                .clear    (acc_clear),
                .load     (1'b0),
                .load_val ({FRAC_W{1'b0}}),
                .step     (tick_d),
                .addend   (bus.BAUD_FRAC),
                .carry    (carry)
            );
        end else begin : g_nofrac
            assign carry = 1'b0;
        end
    endgenerate

    // Divider and oversample counters: disable > resync > reload > count down.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (!bus.ENABLE) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
        end else if (bus.RESYNC) begin
            div_cnt <= {1'b0, bus.BAUD_VAL};
            ovs_cnt <= '0;
        end else if (tick_d) begin
            div_cnt <= {1'b0, bus.BAUD_VAL} + {{DIV_W{1'b0}}, carry};
            ovs_cnt <= ovs_cnt + OVS_W'(1);
        end else begin
            div_cnt <= div_cnt - {{DIV_W{1'b0}}, 1'b1};
        end
    end

    // Registered tick outputs, decoded from the pre-increment ovs_cnt.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ticks <= '0;
        end else begin
            ticks.sample   <= tick_d;
            ticks.mid      <= tick_d & (ovs_cnt == OVS_W'(OVS/2 - 1));
            ticks.boundary <= tick_d & (ovs_cnt == OVS_W'(OVS - 1));
        end
    end

    assign bus.SAMPLE_TICK = ticks.sample;
    assign bus.MID_TICK    = ticks.mid;
    assign bus.BIT_TICK    = ticks.boundary;
endmodule

// File: tb/tb_coreuart_baud_gen_frac.sv
// Bench for coreuart_baud_gen_frac: directed phases push the expected tick
// cycles into a queue; a negedge monitor pops one entry per observed tick.
module tb_coreuart_baud_gen_frac;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;

    typedef struct {
        int cyc;
        bit mid;
        bit bnd;
    } exp_t;

    logic CLK;
    logic RESET;
    int   cyc;
    int   checks;
    int   failures;
    int   n0;
    exp_t exp_q[$];
    int   tick_log[$];
    int   mid_log[$];
    int   bit_log[$];

    coreuart_baud_gen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    coreuart_baud_gen_frac #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Advance to 1 time unit after posedge number t (t must be in the future).
    task automatic goto(input int t);
        do begin
            @(posedge CLK);
            #1;
        end while (cyc < t);
    endtask

    // Queue the ticks of a steady run: first tick at 'first', each tick's
    // reload adds frac to the 4-bit accumulator, carry stretches the period.
    task automatic expect_seq(input int first, input int baud, input int frac,
                              input int acc0, input int ovs0, input int last);
        int c;
        int acc;
        int ovs;
        int cy;
        c   = first;
        acc = acc0;
        ovs = ovs0;
        while (c <= last) begin
            exp_q.push_back('{cyc: c, mid: (ovs == OVS/2 - 1), bnd: (ovs == OVS - 1)});
            acc = acc + frac;
            cy  = (acc >= 16) ? 1 : 0;
            acc = acc % 16;
            c   = c + baud + 1 + cy;
            ovs = (ovs + 1) % OVS;
        end
    endtask

    // Monitor: every visible tick must match the head of the queue.
    always @(negedge CLK) begin
        if (bus.SAMPLE_TICK || bus.MID_TICK || bus.BIT_TICK) begin
            exp_t e;
            tick_log.push_back(cyc);
            if (bus.MID_TICK) mid_log.push_back(cyc);
            if (bus.BIT_TICK) bit_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_tick_cycle", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_sample", bus.SAMPLE_TICK, 1);
                chk("tick_mid", bus.MID_TICK, e.mid);
                chk("tick_bit", bus.BIT_TICK, e.bnd);
            end
        end
    end

    initial begin
        checks         = 0;
        failures       = 0;
        RESET          = 1'b1;
        bus.ENABLE     = 1'b0;
        bus.RESYNC     = 1'b0;
        bus.BAUD_VAL   = '0;
        bus.BAUD_FRAC  = '0;

        goto(2);
        chk("reset_sample", bus.SAMPLE_TICK, 0);
        chk("reset_mid", bus.MID_TICK, 0);
        chk("reset_bit", bus.BIT_TICK, 0);
        goto(3);
        RESET = 1'b0;

        // Integer divide by 4: ticks every 4 cycles, BIT every 64, MID 32 before.
        goto(5);
        bus.BAUD_VAL  = 16'd3;
        bus.BAUD_FRAC = 4'd0;
        bus.ENABLE    = 1'b1;
        expect_seq(6, 3, 0, 0, 0, 132);
        goto(132);
        bus.ENABLE = 1'b0;
        chk("bit_count", bit_log.size(), 2);
        chk("mid_count", mid_log.size(), 2);
        chk("bit_period", bit_log[1] - bit_log[0], 64);
        chk("mid_to_bit0", bit_log[0] - mid_log[0], 32);
        chk("mid_to_bit1", bit_log[1] - mid_log[1], 32);

        // Fraction 8/16: periods 4,5,... 16 periods span 72 cycles.
        goto(140);
        bus.BAUD_FRAC = 4'd8;
        bus.ENABLE    = 1'b1;
        n0 = tick_log.size();
        expect_seq(141, 3, 8, 0, 0, 215);
        goto(215);
        bus.ENABLE = 1'b0;   // low for 10 sampled cycles, no ticks expected
        chk("frac8_span", tick_log[n0+16] - tick_log[n0], 72);

        // Fraction 1/16: fifteen 4s then a 5; 16 periods span 65 cycles.
        goto(225);
        bus.BAUD_FRAC = 4'd1;
        bus.ENABLE    = 1'b1;
        n0 = tick_log.size();
        expect_seq(226, 3, 1, 0, 0, 330);
        goto(300);
        chk("frac1_span", tick_log[n0+16] - tick_log[n0], 65);

        // Resync lands on the reload cycle after the ovs_cnt=9 tick at 327.
        goto(330);
        bus.RESYNC = 1'b1;
        expect_seq(335, 3, 1, 0, 0, 404);
        goto(331);
        bus.RESYNC = 1'b0;

        // BAUD_VAL 3->7 mid-period: 400->404 stays 4, then 8-cycle periods.
        goto(402);
        bus.BAUD_VAL = 16'd7;
        expect_seq(412, 7, 1, 2, 2, 532);

        // Async reset while SAMPLE_TICK is high.
        goto(533);
        chk("pre_reset_sample", bus.SAMPLE_TICK, 1);
        #2;
        RESET         = 1'b1;
        bus.BAUD_VAL  = 16'hFFFF;
        bus.BAUD_FRAC = 4'hF;
        #1;
        chk("async_reset_sample", bus.SAMPLE_TICK, 0);
        chk("async_reset_mid", bus.MID_TICK, 0);
        chk("async_reset_bit", bus.BIT_TICK, 0);

        // Maximum divisor: first tick right after release, next 65536 later.
        goto(536);
        RESET = 1'b0;
        n0 = tick_log.size();
        expect_seq(537, 65535, 15, 0, 0, 66075);
        goto(66075);
        bus.ENABLE = 1'b0;
        chk("max_div_span", tick_log[n0+1] - tick_log[n0], 65536);

        goto(66080);
        chk("expected_ticks_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coreuart_baud_gen_frac.md
Name: coreuart_baud_gen_frac

Overview:
Parametrised baud-rate generator for the UART core and the next generation of the fixed 13-bit / 3-bit-fraction clock generator. It divides the system clock by a runtime integer divisor and a runtime N-bit fractional divisor, using a fractional accumulator that stretches sample periods by one cycle.
- Outputs: an oversample tick, a mid-bit sample tick, and a bit tick, all at a parametrised oversample ratio.
- Adds what the old generator lacks: enable gating, phase resync for the RX start bit, and glitch-free divisor updates.
- Sits between the APB register file (divisor and fraction registers) and the TX/RX shifters.

Parameters:
DIV_W, 16, integer divisor width (2..24)
FRAC_W, 4, fractional divisor width; fraction resolution is 1/2^FRAC_W (0 disables the fraction path)
OVS, 16, oversample ratio; power of two, 4..32

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
ENABLE  in  1  generator run enable (level)
BAUD_VAL  in  DIV_W  integer divisor; sample period = BAUD_VAL+1 cycles
BAUD_FRAC  in  FRAC_W  fractional divisor, in units of 1/2^FRAC_W cycle
RESYNC  in  1  single-cycle pulse that restarts the phase (RX start-bit edge)
SAMPLE_TICK  out  1  oversample tick, one-cycle pulse
MID_TICK  out  1  pulse on the sample tick where ovs_cnt == OVS/2-1 (RX data-sampling point)
BIT_TICK  out  1  pulse on the sample tick where ovs_cnt == OVS-1 (bit boundary, TX shift)

Behaviour:
- Reset: SAMPLE_TICK = MID_TICK = BIT_TICK = 0; div_cnt = 0; frac_acc = 0; ovs_cnt = 0.
- Registers:
  - div_cnt, DIV_W+1 bits (extra bit absorbs BAUD_VAL max + carry).
  - frac_acc, FRAC_W bits.
  - ovs_cnt, log2(OVS) bits.
- Internal term tick_d = ENABLE & !RESYNC & (div_cnt == 0).
- Priority per cycle: ENABLE low > RESYNC > reload > decrement.
- ENABLE low: div_cnt, frac_acc and ovs_cnt are cleared to 0. tick_d = 0.
- RESYNC high (with ENABLE high): div_cnt <= BAUD_VAL, frac_acc <= 0, ovs_cnt <= 0. No tick that cycle.
- Reload (tick_d = 1):
  - Compute {carry, sum} = frac_acc + BAUD_FRAC.
  - frac_acc <= sum.
  - div_cnt <= BAUD_VAL + carry.
  - ovs_cnt <= ovs_cnt + 1, wrapping modulo OVS.
- Otherwise (ENABLE high, div_cnt != 0): div_cnt <= div_cnt - 1.
- Period rule: the gap between consecutive SAMPLE_TICKs is BAUD_VAL+1+carry cycles. Average period = BAUD_VAL+1+BAUD_FRAC/2^FRAC_W.
- Outputs are registered, with 1-cycle latency from tick_d:
  - SAMPLE_TICK <= tick_d.
  - MID_TICK <= tick_d & (ovs_cnt == OVS/2-1).
  - BIT_TICK <= tick_d & (ovs_cnt == OVS-1).
  - ovs_cnt is the pre-increment value.
- First tick after ENABLE rises (counters at 0): SAMPLE_TICK is high in the cycle after ENABLE is first sampled high.
- BAUD_VAL and BAUD_FRAC are sampled only at reload or RESYNC. Mid-period changes take effect at the next tick boundary, so no runt or long period is produced.
- BAUD_VAL = 0, BAUD_FRAC = 0: SAMPLE_TICK is high every enabled cycle.
- BAUD_VAL = 0, BAUD_FRAC != 0: periods of 1 or 2 cycles.
- BAUD_VAL = 2^DIV_W-1 with carry: period = 2^DIV_W+1. No overflow, because div_cnt has the extra bit.
- RESYNC while ENABLE is low: ignored.
- RESYNC and reload in the same cycle: RESYNC wins and no tick is issued. The first post-resync SAMPLE_TICK comes BAUD_VAL+1 cycles later, as a registered output.
- RESET mid-operation: all state returns to the reset values immediately (asynchronous). Counting resumes on the first clock after deassert if ENABLE is high.
- FRAC_W = 0: the accumulator is removed and carry is tied to 0.

Decomposition:
- Shared package coreuart_pkg:
  - OVS_W = $clog2(OVS) helper function.
  - Default DIV_W, FRAC_W and OVS constants.
  - Tick-bundle typedef {sample, mid, bit} for the TX/RX consumers.
- One sub-module, coreuart_frac_acc: the FRAC_W accumulator plus carry output, with load, clear and step inputs. It is reused by the planned autobaud block.
- The divider and oversample counters stay in the top level.

Test Plan:
- DIV_W=16, FRAC_W=4, OVS=16; BAUD_VAL=3, BAUD_FRAC=0, ENABLE=1 -> SAMPLE_TICK every 4 cycles; BIT_TICK every 64 cycles; MID_TICK 32 cycles before each BIT_TICK.
- BAUD_VAL=3, BAUD_FRAC=8 -> sample periods alternate 4,5; 16 SAMPLE_TICKs span exactly 72 cycles.
- BAUD_VAL=3, BAUD_FRAC=1 -> fifteen periods of 4 then one of 5; 16 ticks span 65 cycles.
- RESYNC pulse 2 cycles after a tick with ovs_cnt=9 -> no tick that cycle; next SAMPLE_TICK 4 cycles later; MID_TICK on the 8th post-resync tick; BIT_TICK on the 16th.
- BAUD_VAL changed from 3 to 7 mid-period -> the current period still ends at 4 cycles; subsequent periods are 8 cycles.
- ENABLE low for 10 cycles mid-period, then high -> no ticks while low; SAMPLE_TICK the cycle after re-enable; ovs_cnt restarts at 0.
- RESET asserted asynchronously mid-period -> all outputs 0 in the same cycle. After release with BAUD_VAL=0xFFFF and BAUD_FRAC=0xF, periods of 65536 or 65537 cycles with no wrap error.
